// File: rtl/mips_pipelined.sv
// Five-stage pipelined MIPS32 integer subset core (IF, ID, EX, MEM, WB).
// Internal instruction memory, data memory and register file. There is no
// forwarding and no hazard detection: software spaces dependent instructions
// so that a consumer is at least three instructions after its producer. The
// only bypass is register-file write-through from WB into ID.
module mips_pipelined (
    input logic clk,
    input logic reset
);

    // ALU operations needed by the supported instruction subset
    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT
    } alu_op_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    // ------------------------------------------------------------------
    // Architectural storage. imem is loaded from outside and never written
    // by the core; dmem and regfile are preloaded from outside as well.
    // ------------------------------------------------------------------
    logic [31:0] imem    [0:1023];
    logic [31:0] dmem    [0:1023];
    logic [31:0] regfile [0:31];

    logic [31:0] PC;
    logic [31:0] IF_ID_instr;

    // ID/EX pipeline register
    logic        id_ex_reg_write;
    logic        id_ex_mem_write;
    logic        id_ex_mem_to_reg;
    logic        id_ex_alu_src;
    alu_op_t     id_ex_alu_op;
    logic [4:0]  id_ex_dest;
    logic [31:0] id_ex_rs_val;
    logic [31:0] id_ex_rt_val;
    logic [31:0] id_ex_imm;

    // EX/MEM pipeline register
    logic        ex_mem_reg_write;
    logic        ex_mem_mem_write;
    logic        ex_mem_mem_to_reg;
    logic [4:0]  ex_mem_dest;
    logic [31:0] ex_mem_alu_result;
    logic [31:0] ex_mem_store_data;

    // MEM/WB pipeline register
    logic        mem_wb_reg_write;
    logic        mem_wb_mem_to_reg;
    logic [4:0]  mem_wb_dest;
    logic [31:0] mem_wb_alu_result;
    logic [31:0] mem_wb_load_data;

    // ------------------------------------------------------------------
    // IF stage
    // ------------------------------------------------------------------

    // Fetch: advance PC every cycle and latch the addressed instruction
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, which is what makes the
    // pipeline stages shift in lockstep.
    always_ff @(posedge clk) begin
        if (!reset) begin
            PC          <= 32'h0;
            IF_ID_instr <= 32'h0;
        end else begin
            PC          <= PC + 32'd4;
            IF_ID_instr <= imem[PC[11:2]];
        end
    end

    // ------------------------------------------------------------------
    // ID stage
    // ------------------------------------------------------------------
    logic [5:0]  opcode;
    logic [4:0]  rs_idx;
    logic [4:0]  rt_idx;
    logic [4:0]  rd_idx;
    logic [5:0]  funct;
    logic [15:0] imm16;

    assign opcode = IF_ID_instr[31:26];
    assign rs_idx = IF_ID_instr[25:21];
    assign rt_idx = IF_ID_instr[20:16];
    assign rd_idx = IF_ID_instr[15:11];
    assign funct  = IF_ID_instr[5:0];
    assign imm16  = IF_ID_instr[15:0];

    // The shift-amount field has no meaning for the supported subset
    logic unused_shamt;
    assign unused_shamt = ^IF_ID_instr[10:6];

    logic        dec_reg_write;
    logic        dec_mem_write;
    logic        dec_mem_to_reg;
    logic        dec_alu_src;
    alu_op_t     dec_alu_op;
    logic [4:0]  dec_dest;
    logic        dec_zero_ext;
    logic [31:0] dec_imm;

    // Decode: unsupported encodings keep every control bit low and act as NOP
    // NOTE: every output gets a default before the case statement; a path
    // that leaves one unassigned would infer a latch.
    always_comb begin
        dec_reg_write  = 1'b0;
        dec_mem_write  = 1'b0;
        dec_mem_to_reg = 1'b0;
        dec_alu_src    = 1'b0;
        dec_alu_op     = ALU_ADD;
        dec_dest       = 5'd0;
        dec_zero_ext   = 1'b0;
        unique case (opcode)
            OP_RTYPE: begin
                dec_dest = rd_idx;
                unique case (funct)
                    FN_ADD: begin dec_reg_write = 1'b1; dec_alu_op = ALU_ADD; end
                    FN_SUB: begin dec_reg_write = 1'b1; dec_alu_op = ALU_SUB; end
                    FN_AND: begin dec_reg_write = 1'b1; dec_alu_op = ALU_AND; end
                    FN_OR:  begin dec_reg_write = 1'b1; dec_alu_op = ALU_OR;  end
                    FN_SLT: begin dec_reg_write = 1'b1; dec_alu_op = ALU_SLT; end
                    default: ;
                endcase
            end
            OP_ADDI: begin
                dec_reg_write = 1'b1;
                dec_alu_src   = 1'b1;
                dec_alu_op    = ALU_ADD;
                dec_dest      = rt_idx;
            end
            OP_SLTI: begin
                dec_reg_write = 1'b1;
                dec_alu_src   = 1'b1;
                dec_alu_op    = ALU_SLT;
                dec_dest      = rt_idx;
            end
            OP_ANDI: begin
                dec_reg_write = 1'b1;
                dec_alu_src   = 1'b1;
                dec_alu_op    = ALU_AND;
                dec_dest      = rt_idx;
                dec_zero_ext  = 1'b1;
            end
            OP_ORI: begin
                dec_reg_write = 1'b1;
                dec_alu_src   = 1'b1;
                dec_alu_op    = ALU_OR;
                dec_dest      = rt_idx;
                dec_zero_ext  = 1'b1;
            end
            OP_LW: begin
                dec_reg_write  = 1'b1;
                dec_mem_to_reg = 1'b1;
                dec_alu_src    = 1'b1;
                dec_alu_op     = ALU_ADD;
                dec_dest       = rt_idx;
            end
            OP_SW: begin
                dec_mem_write = 1'b1;
                dec_alu_src   = 1'b1;
                dec_alu_op    = ALU_ADD;
            end
            default: ;
        endcase
    end

    assign dec_imm = dec_zero_ext ? {16'h0, imm16} : {{16{imm16[15]}}, imm16};

    // Writeback data and enable, shared by the register write and the
    // write-through bypass. Register 0 is never written, and nothing is
    // written on an edge where reset is asserted.
    logic [31:0] wb_data;
    logic        wb_en;

    assign wb_data = mem_wb_mem_to_reg ? mem_wb_load_data : mem_wb_alu_result;
    assign wb_en   = reset && mem_wb_reg_write && (mem_wb_dest != 5'd0);

    logic [31:0] rs_val;
    logic [31:0] rt_val;

    assign rs_val = (wb_en && (mem_wb_dest == rs_idx)) ? wb_data : regfile[rs_idx];
    assign rt_val = (wb_en && (mem_wb_dest == rt_idx)) ? wb_data : regfile[rt_idx];

    // ID/EX register: capture decoded controls and operands, clear to NOP on reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            id_ex_reg_write  <= 1'b0;
            id_ex_mem_write  <= 1'b0;
            id_ex_mem_to_reg <= 1'b0;
            id_ex_alu_src    <= 1'b0;
            id_ex_alu_op     <= ALU_ADD;
            id_ex_dest       <= 5'd0;
            id_ex_rs_val     <= 32'h0;
            id_ex_rt_val     <= 32'h0;
            id_ex_imm        <= 32'h0;
        end else begin
            id_ex_reg_write  <= dec_reg_write;
            id_ex_mem_write  <= dec_mem_write;
            id_ex_mem_to_reg <= dec_mem_to_reg;
            id_ex_alu_src    <= dec_alu_src;
            id_ex_alu_op     <= dec_alu_op;
            id_ex_dest       <= dec_dest;
            id_ex_rs_val     <= rs_val;
            id_ex_rt_val     <= rt_val;
            id_ex_imm        <= dec_imm;
        end
    end

    // ------------------------------------------------------------------
    // EX stage
    // ------------------------------------------------------------------
    logic [31:0] alu_b;
    logic [31:0] alu_result;

    assign alu_b = id_ex_alu_src ? id_ex_imm : id_ex_rt_val;

    // ALU: 32-bit wrap-around arithmetic, signed compare for slt/slti
    always_comb begin
        alu_result = 32'h0;
        unique case (id_ex_alu_op)
            ALU_ADD: alu_result = id_ex_rs_val + alu_b;
            ALU_SUB: alu_result = id_ex_rs_val - alu_b;
            ALU_AND: alu_result = id_ex_rs_val & alu_b;
            ALU_OR:  alu_result = id_ex_rs_val | alu_b;
            ALU_SLT: alu_result = {31'h0, $signed(id_ex_rs_val) < $signed(alu_b)};
            default: alu_result = 32'h0;
        endcase
    end

    // EX/MEM register: capture ALU result and store data, clear to NOP on reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            ex_mem_reg_write  <= 1'b0;
            ex_mem_mem_write  <= 1'b0;
            ex_mem_mem_to_reg <= 1'b0;
            ex_mem_dest       <= 5'd0;
            ex_mem_alu_result <= 32'h0;
            ex_mem_store_data <= 32'h0;
        end else begin
            ex_mem_reg_write  <= id_ex_reg_write;
            ex_mem_mem_write  <= id_ex_mem_write;
            ex_mem_mem_to_reg <= id_ex_mem_to_reg;
            ex_mem_dest       <= id_ex_dest;
            ex_mem_alu_result <= alu_result;
            ex_mem_store_data <= id_ex_rt_val;
        end
    end

    // ------------------------------------------------------------------
    // MEM stage: word-addressed, the low two address bits are ignored
    // ------------------------------------------------------------------
    logic [9:0]  dmem_index;
    logic [31:0] load_data;

    assign dmem_index = ex_mem_alu_result[11:2];
    assign load_data  = dmem[dmem_index];

    // Data memory write port for sw
    // NOTE: dmem has no reset branch; memory contents survive reset and are
    // loaded from outside, only the write is blocked while reset is low.
    always_ff @(posedge clk) begin
        if (reset && ex_mem_mem_write) begin
            dmem[dmem_index] <= ex_mem_store_data;
        end
    end

    // MEM/WB register: capture load data and ALU result, clear to NOP on reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            mem_wb_reg_write  <= 1'b0;
            mem_wb_mem_to_reg <= 1'b0;
            mem_wb_dest       <= 5'd0;
            mem_wb_alu_result <= 32'h0;
            mem_wb_load_data  <= 32'h0;
        end else begin
            mem_wb_reg_write  <= ex_mem_reg_write;
            mem_wb_mem_to_reg <= ex_mem_mem_to_reg;
            mem_wb_dest       <= ex_mem_dest;
            mem_wb_alu_result <= ex_mem_alu_result;
            mem_wb_load_data  <= load_data;
        end
    end

    // ------------------------------------------------------------------
    // WB stage
    // ------------------------------------------------------------------

    // Register file write port; register 0 is never written
    always_ff @(posedge clk) begin
        if (wb_en) begin
            regfile[mem_wb_dest] <= wb_data;
        end
    end

endmodule

// File: tb/tb_mips_pipelined.sv
// Self-checking bench for mips_pipelined: single-instruction vector table,
// a hand-written program with the hazard-spacing corner cases, reset
// sequences, and random hazard-free programs against an ISA-level model.
module tb_mips_pipelined;

    logic clk = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    mips_pipelined dut (
        .clk   (clk),
        .reset (reset)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 1024; i++) dut.imem[i] = 32'h0;
    endtask

    // Leaves the bench at a falling edge with reset low and the pipeline cleared,
    // so memories and registers can be preloaded without racing a writeback.
    task automatic hold_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic release_run(input int n);
        reset = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // ------------------------------------------------------------------
    // Single-instruction vectors
    // ------------------------------------------------------------------
    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [31:0] rs_val;
        logic [31:0] rt_val;
        logic [4:0]  dest;
        logic [31:0] expected;
    } vec_t;

    vec_t vecs[15];

    // ------------------------------------------------------------------
    // ISA-level reference model for random programs
    // ------------------------------------------------------------------
    typedef enum {
        K_ADD, K_SUB, K_AND, K_OR, K_SLT,
        K_ADDI, K_ANDI, K_ORI, K_SLTI, K_LW, K_SW, K_BAD
    } kind_t;

    typedef struct {
        kind_t       kind;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [15:0] imm;
    } ins_t;

    logic [31:0] mr [0:31];
    logic [31:0] md [0:1023];

    function automatic logic [31:0] encode(input ins_t in);
        logic [5:0] fn;
        logic [5:0] op;
        fn = 6'h00;
        op = 6'h3F;
        case (in.kind)
            K_ADD: fn = 6'h20;
            K_SUB: fn = 6'h22;
            K_AND: fn = 6'h24;
            K_OR:  fn = 6'h25;
            K_SLT: fn = 6'h2A;
            K_ADDI: op = 6'h08;
            K_ANDI: op = 6'h0C;
            K_ORI:  op = 6'h0D;
            K_SLTI: op = 6'h0A;
            K_LW:   op = 6'h23;
            K_SW:   op = 6'h2B;
            default: op = 6'h3F;
        endcase
        if (in.kind inside {K_ADD, K_SUB, K_AND, K_OR, K_SLT})
            return {6'h00, in.rs, in.rt, in.rd, 5'h00, fn};
        return {op, in.rs, in.rt, in.imm};
    endfunction

    // Executes one instruction on the sequential architectural model
    task automatic model_exec(input ins_t in);
        logic [31:0] a, b, simm, zimm, res, addr;
        logic [4:0]  dst;
        bit          wr;
        a    = mr[in.rs];
        b    = mr[in.rt];
        simm = {{16{in.imm[15]}}, in.imm};
        zimm = {16'h0, in.imm};
        res  = 32'h0;
        dst  = in.rt;
        wr   = 1'b1;
        case (in.kind)
            K_ADD:  begin res = a + b; dst = in.rd; end
            K_SUB:  begin res = a - b; dst = in.rd; end
            K_AND:  begin res = a & b; dst = in.rd; end
            K_OR:   begin res = a | b; dst = in.rd; end
            K_SLT:  begin res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; dst = in.rd; end
            K_ADDI: res = a + simm;
            K_ANDI: res = a & zimm;
            K_ORI:  res = a | zimm;
            K_SLTI: res = ($signed(a) < $signed(simm)) ? 32'd1 : 32'd0;
            K_LW:   begin addr = a + simm; res = md[(addr / 4) % 1024]; end
            K_SW:   begin addr = a + simm; md[(addr / 4) % 1024] = b; wr = 1'b0; end
            default: wr = 1'b0;
        endcase
        if (wr && dst != 5'd0) mr[dst] = res;
    endtask

    initial begin
        // inputs: instr, rs ($1), rt ($2); outputs: dest register and value
        vecs[0]  = '{"add_ovf",    32'h00221820, 32'h7FFFFFFF, 32'h00000001, 5'd3, 32'h80000000};
        vecs[1]  = '{"sub_neg",    32'h00221822, 32'h00000005, 32'h00000007, 5'd3, 32'hFFFFFFFE};
        vecs[2]  = '{"and",        32'h00221824, 32'h0000F0F0, 32'h0000FF00, 5'd3, 32'h0000F000};
        vecs[3]  = '{"or",         32'h00221825, 32'h0000F0F0, 32'h00000F0F, 5'd3, 32'h0000FFFF};
        vecs[4]  = '{"slt_neg",    32'h0022182A, 32'hFFFFFFFF, 32'h00000001, 5'd3, 32'h00000001};
        vecs[5]  = '{"slt_pos",    32'h0022182A, 32'h00000001, 32'hFFFFFFFF, 5'd3, 32'h00000000};
        vecs[6]  = '{"addi_m1",    32'h2022FFFF, 32'h00000005, 32'h22222222, 5'd2, 32'h00000004};
        vecs[7]  = '{"andi_zext",  32'h3022FFFF, 32'hFFFFFFFF, 32'h22222222, 5'd2, 32'h0000FFFF};
        vecs[8]  = '{"ori_zext",   32'h34228000, 32'h00000001, 32'h22222222, 5'd2, 32'h00008001};
        vecs[9]  = '{"slti_neg",   32'h2822FFFF, 32'hFFFFFFFE, 32'h22222222, 5'd2, 32'h00000001};
        vecs[10] = '{"slti_min",   32'h28228000, 32'h7FFFFFFF, 32'h22222222, 5'd2, 32'h00000000};
        vecs[11] = '{"bad_op",     32'hFC22FFFF, 32'h00000001, 32'h22222222, 5'd2, 32'h22222222};
        vecs[12] = '{"bad_funct",  32'h00221821, 32'h00000001, 32'h00000002, 5'd3, 32'hDEAD0003};
        vecs[13] = '{"add_to_r0",  32'h00220020, 32'h00000001, 32'h00000002, 5'd0, 32'h00000000};
        vecs[14] = '{"lw_lowbits", 32'h8C220008, 32'h00000007, 32'h22222222, 5'd2, 32'hCAFEF00D};

        // ---------------- reset behaviour ----------------
        for (int i = 0; i < 1024; i++) dut.imem[i] = 32'hFC000000 | i;
        dut.regfile[5] = 32'hA5A5A5A5;
        dut.dmem[3]    = 32'h5A5A5A5A;
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("reset_pc", dut.PC, 32'h0);
        check("reset_ifid", dut.IF_ID_instr, 32'h0);
        check("reset_reg_kept", dut.regfile[5], 32'hA5A5A5A5);
        check("reset_dmem_kept", dut.dmem[3], 32'h5A5A5A5A);
        reset = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            check($sformatf("fetch_pc_%0d", n), dut.PC, 32'(4 * n));
            check($sformatf("fetch_ifid_%0d", n), dut.IF_ID_instr, 32'hFC000000 | (n - 1));
        end

        // ---------------- single-instruction vectors ----------------
        clear_imem();
        for (int v = 0; v < 15; v++) begin
            hold_reset();
            dut.regfile[0] = 32'h0;
            dut.regfile[1] = vecs[v].rs_val;
            dut.regfile[2] = vecs[v].rt_val;
            dut.regfile[3] = 32'hDEAD0003;
            dut.dmem[3]    = 32'hCAFEF00D;
            dut.imem[0]    = vecs[v].instr;
            release_run(7);
            check(vecs[v].name, dut.regfile[vecs[v].dest], vecs[v].expected);
        end

        // ---------------- hand-written program ----------------
        hold_reset();
        clear_imem();
        for (int i = 0; i < 32; i++) dut.regfile[i] = 32'h0;
        dut.regfile[13] = 32'h7FFFFFFF;
        dut.regfile[14] = 32'h00000001;
        dut.dmem[4]     = 32'h0;
        dut.imem[0]  = 32'h20100005; // addi $s0,$0,5
        dut.imem[1]  = 32'h2011000A; // addi $s1,$0,10
        dut.imem[5]  = 32'h02304020; // add  $t0,$s1,$s0
        dut.imem[6]  = 32'h3212000F; // andi $s2,$s0,0xF
        dut.imem[7]  = 32'h363300F0; // ori  $s3,$s1,0xF0
        dut.imem[8]  = 32'h2A34000A; // slti $s4,$s1,10
        dut.imem[9]  = 32'h2A35FFFF; // slti $s5,$s1,-1
        dut.imem[11] = 32'hAC080010; // sw   $t0,16($0)
        dut.imem[14] = 32'h8C090010; // lw   $t1,16($0)
        dut.imem[15] = 32'h201600FF; // addi $s6,$0,0xFF
        dut.imem[16] = 32'h20000007; // addi $0,$0,7
        dut.imem[17] = 32'h01295020; // add  $t2,$t1,$t1 (2 instrs after lw)
        dut.imem[20] = 32'h200B0033; // addi $11,$0,0x33
        dut.imem[23] = 32'h216C0001; // addi $12,$11,1 (exactly 2 NOPs between)
        dut.imem[24] = 32'h01AE7820; // add  $15,$13,$14 (overflow wraps)
        release_run(35);
        check("prog_s0", dut.regfile[16], 32'd5);
        check("prog_s1", dut.regfile[17], 32'd10);
        check("prog_add", dut.regfile[8], 32'd15);
        check("prog_andi", dut.regfile[18], 32'd5);
        check("prog_ori", dut.regfile[19], 32'h000000FA);
        check("prog_slti", dut.regfile[20], 32'd0);
        check("prog_slti_m1", dut.regfile[21], 32'd0);
        check("prog_sw", dut.dmem[4], 32'd15);
        check("prog_lw", dut.regfile[9], 32'd15);
        check("prog_addi_ff", dut.regfile[22], 32'h000000FF);
        check("prog_r0", dut.regfile[0], 32'h0);
        check("prog_lw_use", dut.regfile[10], 32'd30);
        check("prog_prod", dut.regfile[11], 32'h00000033);
        check("prog_wthru", dut.regfile[12], 32'h00000034);
        check("prog_ovf", dut.regfile[15], 32'h80000000);

        // ---------------- reset mid-program ----------------
        hold_reset();
        clear_imem();
        dut.regfile[16] = 32'h0;
        dut.regfile[17] = 32'h00001111;
        dut.imem[0] = 32'h20100005; // commits at edge 5
        dut.imem[1] = 32'h2011000A; // would commit at edge 6
        release_run(5);
        reset = 1'b0;
        @(negedge clk);
        check("mid_pc", dut.PC, 32'h0);
        check("mid_ifid", dut.IF_ID_instr, 32'h0);
        check("mid_committed", dut.regfile[16], 32'd5);
        check("mid_cancelled", dut.regfile[17], 32'h00001111);
        repeat (3) @(negedge clk);
        check("mid_still_cancelled", dut.regfile[17], 32'h00001111);

        // ---------------- random hazard-free programs ----------------
        for (int rep = 0; rep < 8; rep++) begin
            ins_t prog [20];
            hold_reset();
            clear_imem();
            for (int i = 0; i < 32; i++) mr[i] = 32'h0;
            for (int i = 1; i < 8; i++) mr[i] = $urandom;
            for (int i = 0; i < 1024; i++) md[i] = 32'h0;
            for (int i = 0; i < 16; i++) md[i] = $urandom;
            for (int i = 0; i < 32; i++) dut.regfile[i] = mr[i];
            for (int i = 0; i < 16; i++) dut.dmem[i] = md[i];
            for (int i = 0; i < 20; i++) begin
                prog[i].kind = kind_t'($urandom_range(0, 11));
                prog[i].rs   = 5'($urandom_range(0, 7));
                prog[i].rt   = 5'($urandom_range(0, 7));
                prog[i].rd   = 5'($urandom_range(0, 7));
                prog[i].imm  = 16'($urandom);
                if (prog[i].kind == K_LW || prog[i].kind == K_SW) begin
                    prog[i].rs  = 5'd0;
                    prog[i].imm = 16'($urandom_range(0, 63));
                end
                dut.imem[i * 3] = encode(prog[i]);
            end
            for (int i = 0; i < 20; i++) model_exec(prog[i]);
            release_run(66);
            for (int i = 0; i < 8; i++)
                check($sformatf("rand%0d_reg%0d", rep, i), dut.regfile[i], mr[i]);
            for (int i = 0; i < 16; i++)
                check($sformatf("rand%0d_mem%0d", rep, i), dut.dmem[i], md[i]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mips_pipelined.md
# mips_pipelined

Five-stage pipelined MIPS32 integer subset core (IF, ID, EX, MEM, WB) with internal instruction memory, data memory and register file. It has no forwarding and no hazard detection: software must space dependent instructions, using 0x00000000 as a NOP. It is the top-level CPU block. Benches preload memories and registers and inspect state through fixed internal hierarchical names.

## Interface
- Parameters: none. Sizes are fixed: 1024-word imem, 1024-word dmem, 32 registers.
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- Required internal names, directly accessible by benches:
  - imem[0:1023] (32b)
  - dmem[0:1023] (32b)
  - regfile[0:31] (32b)
  - PC (32b)
  - IF_ID_instr (32b)

## Operation
- Supported instructions; any other encoding executes as a NOP (no register or memory write):
  - R-type, opcode 0, funct: add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A; destination rd.
  - I-type opcodes, destination rt: addi 0x08, andi 0x0C, ori 0x0D, slti 0x0A, lw 0x23, sw 0x2B.
- Immediates:
  - addi, slti, lw, sw: sign-extend imm16.
  - andi, ori: zero-extend imm16.
- Arithmetic: 32-bit wrap-around, no overflow trap. slt and slti compare signed.
- Addressing: byte addresses.
  - imem index = PC[11:2].
  - dmem index = (rs + simm)[11:2]; low two address bits are ignored.
  - Accesses are word-only.
- 0x00000000 (sll $0,$0,0) is a NOP: R-type with rd=0 performs no write.
- Writes to register 0 are suppressed; regfile[0] is never modified.
- Register file:
  - Two combinational read ports in ID, one write port in WB.
  - Write-through: an ID read of the register being written in the same cycle returns the new WB data.
- Pipeline registers: IF/ID, ID/EX, EX/MEM, MEM/WB. Each carries the instruction's control bits:
  - RegWrite, MemWrite, MemToReg, ALUSrc, ALU op, destination register.
- No stalls or flushes. PC += 4 every cycle when not in reset. PC wraps naturally at 32 bits; imem indexing wraps every 4 KB.
- Software hazard rule:
  - A consumer must be at least 3 instructions after its producer, i.e. at least 2 intervening instructions.
  - This applies equally to lw results.
- Reset (reset low at a rising edge):
  - PC <= 0.
  - All pipeline registers cleared to NOP with all control bits 0; IF_ID_instr <= 0.
  - No regfile or dmem writes occur.
  - imem, dmem and regfile contents are NOT reset; they are preloaded externally.
- Reset asserted mid-execution: in-flight instructions are discarded. Writes already committed remain.

## Timing
- Instruction at address A is fetched at edge k, when IF_ID_instr <= imem[A>>2]. After that edge:
  - ID/EX at edge k+1.
  - EX/MEM at edge k+2.
  - Store writes dmem at edge k+3.
  - Register write at edge k+4.
- First edge with reset high loads IF_ID_instr <= imem[0] and sets PC to 4.
- Load data: dmem is read combinationally in MEM, registered into MEM/WB at k+3, and written to the regfile at k+4.
- Throughput: one instruction per cycle; CPI 1.

## Test plan
- Program of addi, addi, add, each followed by NOPs, with 3 NOPs before the add:
  - addi $s0,$0,5 (0x20100005); addi $s1,$0,10 (0x2011000A); add $t0,$s1,$s0 (0x02304020).
  - Required: regfile[16]=5, regfile[17]=10, regfile[8]=15.
- Logic and compare:
  - andi $s2,$s0,0xF (0x3212000F) -> regfile[18]=5.
  - ori $s3,$s1,0xF0 (0x363300F0) -> regfile[19]=0xFA.
  - slti $s4,$s1,10 (0x2A34000A) -> regfile[20]=0.
  - slti with imm 0xFFFF and $s1=10 -> 0.
- Memory:
  - sw $t0,16($0) (0xAC080010) -> dmem[4]=15.
  - Then lw $t1,16($0) (0x8C090010) -> regfile[9]=15.
  - Then addi $s6,$0,0xFF -> regfile[22]=0xFF.
- Reset behaviour:
  - Hold reset low for 5 cycles -> PC=0, IF_ID_instr=0, no state changes.
  - Release -> PC=4 after the first edge, and IF_ID_instr matches imem[PC/4] each cycle.
  - Re-assert reset mid-program -> PC returns to 0; the in-flight writeback is cancelled.
- Edge cases:
  - addi $0,$0,7 -> regfile[0] stays 0.
  - Producer followed by exactly 2 NOPs then a consumer -> consumer sees the new value via write-through.
  - add overflow 0x7FFFFFFF+1 -> 0x80000000, no trap.
